clause_fifo_drain: RTL

// Parametrised successor to the fixed 4/2/1 clause FIFO tree. Captures a vector of CLAUSE_COUNT

---
 rtl/clause_fifo_drain.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/clause_fifo_drain.sv
// clause_fifo_drain
//   Captures a vector of CLAUSE_COUNT candidate clauses with per-clause valid
//   bits, then drains the valid ones, lowest index first, into an output FIFO
//   at one clause per cycle. With OF_MODE=0 a clause meeting a full FIFO is
//   dropped and counted; with OF_MODE=1 the drain stalls until space opens.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-low reset
//   clauses_i      : clause j at [CLAUSE_WIDTH*j +: CLAUSE_WIDTH]
//   clause_valid_i : bit j qualifies clause j
//   wren           : capture request, honoured only while wr_ready=1
//   wr_ready       : capture register holds no pending clauses
//   rden           : pop the FIFO head (ignored while empty)
//   cOF            : clear OF and drop_count
//   clause_o       : FIFO head (show-ahead), zero while empty
//   empty / full   : FIFO occupancy flags
//   count          : FIFO occupancy
//   OF             : sticky overflow / rejected-capture flag
//   drop_count     : clauses lost since the last cOF, saturating
module clause_fifo_drain #(
  parameter int CLAUSE_COUNT = 20,
  parameter int CLAUSE_WIDTH = 9,
  parameter int BUFFER_DEPTH = 16,
  parameter int OF_MODE      = 0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0]   clauses_i,
  input  logic [CLAUSE_COUNT-1:0]                clause_valid_i,
  input  logic                                   wren,
  output logic                                   wr_ready,
  input  logic                                   rden,
  input  logic                                   cOF,
  output logic [CLAUSE_WIDTH-1:0]                clause_o,
  output logic                                   empty,
  output logic                                   full,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]      count,
  output logic                                   OF,
  output logic [15:0]                            drop_count
);

  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int IDX_W = $clog2(CLAUSE_COUNT);
  // Wide enough for a full rejected vector plus one drain drop in one cycle.
  localparam int INC_W = $clog2(CLAUSE_COUNT + 2);
  localparam bit STALL_MODE = (OF_MODE != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [CLAUSE_COUNT-1:0] v);
    lowest_idx = '0;
    for (int i = CLAUSE_COUNT - 1; i >= 0; i--) begin
      lowest_idx = v[i] ? IDX_W'(i) : lowest_idx;
    end
  endfunction

  function automatic logic [INC_W-1:0] popcount(input logic [CLAUSE_COUNT-1:0] v);
    popcount = '0;
    for (int i = 0; i < CLAUSE_COUNT; i++) begin
      popcount = popcount + INC_W'(v[i]);
    end
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [INC_W-1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    sat_add = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  state_t                            state_r, state_nxt_s;
  logic [CLAUSE_COUNT-1:0]           mask_r;
  logic [CLAUSE_COUNT*CLAUSE_WIDTH-1:0] data_r;
  logic [CLAUSE_WIDTH-1:0]           mem_r [BUFFER_DEPTH];
  logic [PTR_W-1:0]                  wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]                  count_r;
  logic                              of_r;
  logic [15:0]                       drop_count_r;

  logic                              wr_ready_s, empty_s, full_s, pop_s, room_s;
  logic                              capture_s, reject_s, last_bit_s;
  logic [IDX_W-1:0]                  sel_idx_s;
  logic [CLAUSE_COUNT-1:0]           sel_onehot_s;
  logic [CLAUSE_WIDTH-1:0]           sel_clause_s;
  logic                              push_s, drop_s, clear_bit_s, of_event_s;
  logic [INC_W-1:0]                  inc_s;

  assign wr_ready_s   = (mask_r == '0);
  assign empty_s      = (count_r == '0);
  assign full_s       = (count_r == CNT_W'(BUFFER_DEPTH));
  assign pop_s        = rden && !empty_s;
  // A push at full is still legal when the same cycle pops the head.
  assign room_s       = !full_s || pop_s;
  assign capture_s    = wren && wr_ready_s;
  assign reject_s     = wren && !wr_ready_s;
  assign sel_idx_s    = lowest_idx(mask_r);
  assign sel_onehot_s = {{(CLAUSE_COUNT-1){1'b0}}, 1'b1} << sel_idx_s;
  assign sel_clause_s = data_r[CLAUSE_WIDTH*sel_idx_s +: CLAUSE_WIDTH];
  assign last_bit_s   = ((mask_r & ~sel_onehot_s) == '0);
  assign of_event_s   = reject_s || drop_s;
  assign inc_s        = (reject_s ? popcount(clause_valid_i) : INC_W'(1'b0))
                      + (drop_s ? INC_W'(1'b1) : INC_W'(1'b0));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s && (clause_valid_i != '0)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (STALL_MODE && !room_s) begin
          state_nxt_s = ST_STALL;
        end else if (clear_bit_s && last_bit_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_STALL: begin
        // Resume only once a pop has actually freed a slot.
        if (pop_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: push, drop, and retire of the selected pending bit.
  always_comb begin
    push_s      = 1'b0;
    drop_s      = 1'b0;
    clear_bit_s = 1'b0;
    case (state_r)
      ST_DRAIN: begin
        if (room_s) begin
          push_s      = 1'b1;
          clear_bit_s = 1'b1;
        end else if (!STALL_MODE) begin
          drop_s      = 1'b1;
          clear_bit_s = 1'b1;
        end else begin
          clear_bit_s = 1'b0;
        end
      end
      ST_IDLE: begin
        push_s = 1'b0;
      end
      ST_STALL: begin
        push_s = 1'b0;
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Pending mask: loaded on capture, one bit retired per drain step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mask_r <= '0;
    end else if (capture_s) begin
      mask_r <= clause_valid_i;
    end else if (clear_bit_s) begin
      mask_r <= mask_r & ~sel_onehot_s;
    end
  end

  // Captured clause data; only read under a set mask bit, so no reset needed.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      data_r <= clauses_i;
    end
  end

  // FIFO storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (reset && push_s) begin
      mem_r[wr_ptr_r] <= sel_clause_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at BUFFER_DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Overflow flag and loss counter; an event in the clear cycle wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      of_r         <= 1'b0;
      drop_count_r <= 16'd0;
    end else if (cOF) begin
      of_r         <= of_event_s;
      drop_count_r <= 16'(inc_s);
    end else begin
      of_r         <= of_r | of_event_s;
      drop_count_r <= sat_add(drop_count_r, inc_s);
    end
  end

  assign wr_ready   = wr_ready_s;
  assign empty      = empty_s;
  assign full       = full_s;
  assign count      = count_r;
  assign OF         = of_r;
  assign drop_count = drop_count_r;
  assign clause_o   = empty_s ? '0 : mem_r[rd_ptr_r];

endmodule
